riscv_if_fetch: RTL
===================

// Module: riscv_if_fetch
// PURPOSE
//  Instruction-fetch stage: the producer that feeds the decode stage with pc_o/inst_o.
//  It holds the fetch PC and issues one-outstanding word reads to instruction memory.
//  Returned words go into a small prefetch FIFO of {pc, inst} pairs; decode drains it under stall control.
//  A branch/jump redirect from execute flushes the FIFO, discards the in-flight read and restarts at the target.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  4              prefetch entries (power of 2, >=2)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  imem_req_o   out  1   read request to instruction memory
//  imem_addr_o  out  32  word-aligned read address, valid with imem_req_o
//  imem_ack_i   in   1   read complete; imem_data_i valid this cycle
//  imem_data_i  in   32  instruction word returned
//  br_taken_i   in   1   redirect request (taken branch / jal), one-cycle pulse
//  br_target_i  in   32  redirect address, valid with br_taken_i
//  stall_i      in   1   downstream not accepting this cycle
//  pc_o         out  32  PC of instruction at FIFO head
//  inst_o       out  32  instruction at FIFO head; 32'h0000_0013 (nop) when !inst_valid_o
//  inst_valid_o out  1   FIFO non-empty
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0; imem_req_o=0,
//   imem_addr_o=RESET_PC, pc_o=0, inst_o=nop, inst_valid_o=0. Reset mid-read drops the read.
//  Request FSM: IDLE / WAIT.
//   IDLE: if !br_taken_i and (count+0) < FIFO_DEPTH -> drive imem_req_o=1, addr=fetch_pc, go WAIT.
//   WAIT: hold imem_req_o=1 and addr stable until imem_ack_i; on ack: req drops next cycle, go IDLE.
//   Only one read outstanding; a new request may be issued the cycle after an ack (2-cycle min per word).
//  Ack in WAIT without discard: push {fetch_pc, imem_data_i}; fetch_pc += 4 (32-bit wrap 0xFFFF_FFFC->0).
//   Push is guaranteed room: request only issued when count < FIFO_DEPTH counting its own slot.
//  Consume: pop when inst_valid_o && !stall_i; head advances next cycle. Push and pop same cycle -> count unchanged.
//  Output latency: ack at cycle N -> inst_valid_o/inst_o/pc_o visible cycle N+1 (registered FIFO head).
//  Redirect (br_taken_i=1), highest priority:
//   FIFO flushed (count=0, inst_valid_o=0 next cycle, no pop that cycle); fetch_pc=br_target_i & ~32'h3.
//   If in WAIT: set discard=1; the pending ack is dropped (no push, no pc increment), then IDLE, discard=0.
//   Ack and redirect in the same cycle: the word is dropped, no discard needed; go IDLE with new pc.
//   No new request in the redirect cycle; first target request earliest next cycle.
//  Redirect while discard=1: target replaced; still one ack to drop.
//  stall_i has no effect on requests except through FIFO fullness.
//  Pointers: log2(FIFO_DEPTH) bits wrapping; count is log2(FIFO_DEPTH)+1 bits.
// TESTING
//  T1 reset: rst high mid-WAIT -> req_o=0, valid=0, inst_o=nop; after release first addr=RESET_PC.
//  T2 streaming, ack 1 cycle after req, stall_i=0 -> pc_o sequence 0,4,8,12 with matching words, no gaps beyond 2 cycles.
//  T3 stall_i=1 held -> exactly 4 words buffered, req_o stays 0; release -> drains 0,4,8,12 in 4 cycles, fetch resumes at 16.
//  T4 redirect to 0x100 while WAIT on 0x8 -> ack data for 0x8 dropped; next req addr=0x100; valid=0 until 0x100 word arrives.
//  T5 redirect coincident with ack and pop -> FIFO empty next cycle, no stale pc_o, next req addr=target.
//  T6 wrap: RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/riscv_if_fetch.sv
// ============================================================================
// riscv_if_fetch : instruction-fetch stage, one-outstanding imem reads into a
//                  {pc, inst} prefetch FIFO drained by decode.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module riscv_if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_fetch_pc;
  logic          r_discard;

  logic [31:0]   r_pc_mem   [FIFO_DEPTH];
  logic [31:0]   r_inst_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [31:0]   w_target;

  assign w_valid  = (r_count != '0);
  assign w_target = br_target_i & ~32'h3;
  assign w_push   = (r_state == S_WAIT) && imem_ack_i && !r_discard && !br_taken_i;
  assign w_pop    = w_valid && !stall_i && !br_taken_i;
  // Only one read can be in flight, so an empty slot now is a slot at ack time.
  assign w_issue  = (r_state == S_IDLE) && !br_taken_i && (r_count < (AW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (br_taken_i) begin
            r_fetch_pc <= w_target;
          end else if (w_issue) begin
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack_i) begin
            r_req     <= 1'b0;
            r_discard <= 1'b0;
            r_state   <= S_IDLE;
            if (br_taken_i) begin
              r_fetch_pc <= w_target;
            end else if (!r_discard) begin
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end
          end else if (br_taken_i) begin
            // Keep the bus request alive until the stale word returns.
            r_discard  <= 1'b1;
            r_fetch_pc <= w_target;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (br_taken_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= imem_data_i;
    end
  end

  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_addr;
  assign inst_valid_o = w_valid;
  assign pc_o         = w_valid ? r_pc_mem[r_rd_ptr]   : 32'h0000_0000;
  assign inst_o       = w_valid ? r_inst_mem[r_rd_ptr] : C_NOP;

endmodule

`default_nettype wire
